// File: rtl/vga_scan_compositor.sv
// rtl/vga_scan_compositor.sv - 640x480@60 VGA raster generator with sprite-over-background compositing
//
// Purpose: free-running h/v scan counters that drive x/y to the sprite renderers.
//          The renderer RGBA is composited over a background colour. RGB and the
//          syncs are then registered in one common stage, so pixel data and syncs
//          leave on the same clock edge.
// Optional feature: define VGA_TEST_PATTERN_EN to replace BG_RGB with eight
//          80-pixel vertical colour bars.
// Ports:
//   clk, rst_n          - single clock, asynchronous active-low reset
//   pix_en              - pixel strobe; all state advances only when high
//   x, y                - current scan position (h/v counters), to renderers
//   spr_r/g/b, spr_a    - renderer colour and opacity for the current x/y
//   vga_r/g/b           - registered colour to the DAC (zero outside visible area)
//   vga_hsync/vga_vsync - registered active-low syncs
//   vga_blank_n         - registered visible-area flag
//   frame_start         - one-clk pulse when the counters wrap to (0,0)
module vga_scan_compositor #(
    parameter int          H_VISIBLE = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_VISIBLE = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter logic [23:0] BG_RGB    = 24'h000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [7:0] spr_r,
    input  logic [7:0] spr_g,
    input  logic [7:0] spr_b,
    input  logic       spr_a,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic       frame_start
);

    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, fs_q, fs_d;

    logic        h_last, v_last, vis, hs_n, vs_n;
    logic [23:0] bg_rgb, pix_rgb;

`ifdef VGA_TEST_PATTERN_EN
    // h[9:7] would give 128-px bars, so the 80-px bar index comes from comparators.
    always_comb begin
        bg_rgb = 24'h000000;
        if      (h_q < 10'd80)  bg_rgb = 24'hFFFFFF;
        else if (h_q < 10'd160) bg_rgb = 24'hFFFF00;
        else if (h_q < 10'd240) bg_rgb = 24'h00FFFF;
        else if (h_q < 10'd320) bg_rgb = 24'h00FF00;
        else if (h_q < 10'd400) bg_rgb = 24'hFF00FF;
        else if (h_q < 10'd480) bg_rgb = 24'hFF0000;
        else if (h_q < 10'd560) bg_rgb = 24'h0000FF;
        else                    bg_rgb = 24'h000000;
    end
`else
    assign bg_rgb = BG_RGB;
`endif

    always_comb begin
        h_last  = (h_q == H_LAST);
        v_last  = (v_q == V_LAST);
        vis     = (h_q < H_VIS) && (v_q < V_VIS);
        hs_n    = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs_n    = !((v_q >= VS_BEG) && (v_q < VS_END));
        pix_rgb = vis ? (spr_a ? {spr_r, spr_g, spr_b} : bg_rgb) : 24'h0;

        h_d       = h_q;
        v_d       = v_q;
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        fs_d      = 1'b0;

        if (pix_en) begin
            h_d = h_last ? 10'd0 : h_q + 10'd1;
            if (h_last) begin
                v_d = v_last ? 10'd0 : v_q + 10'd1;
            end
            // Output stage samples the pixel at the pre-increment position,
            // giving data and syncs the same one-strobe latency behind x/y.
            rgb_d     = pix_rgb;
            hs_d      = hs_n;
            vs_d      = vs_n;
            blank_n_d = vis;
            fs_d      = h_last && v_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= 10'd0;
            v_q       <= 10'd0;
            rgb_q     <= 24'h0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            fs_q      <= fs_d;
        end
    end

    assign x           = h_q;
    assign y           = v_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign vga_blank_n = blank_n_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// tb/tb_vga_scan_compositor.sv - scoreboard and vector bench for vga_scan_compositor
module tb_vga_scan_compositor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, pix_en;
    logic [9:0] x0, y0, x1, y1;
    logic [7:0] sr0, sg0, sb0c, sr1, sg1, sb1c;
    logic       sa0, sa1;
    logic [7:0] vr0, vg0, vb0, vr1, vg1, vb1;
    logic       hs0, vs0, bl0, fs0, hs1, vs1, bl1, fs1;

    // Renderer 0: single opaque red pixel at (100,50). Renderer 1: opaque white everywhere.
    assign sa0  = (x0 == 10'd100) && (y0 == 10'd50);
    assign sr0  = 8'hFF;
    assign sg0  = 8'h00;
    assign sb0c = 8'h00;
    assign sa1  = 1'b1;
    assign sr1  = 8'hFF;
    assign sg1  = 8'hFF;
    assign sb1c = 8'hFF;

    vga_scan_compositor dut0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x0), .y(y0),
        .spr_r(sr0), .spr_g(sg0), .spr_b(sb0c), .spr_a(sa0),
        .vga_r(vr0), .vga_g(vg0), .vga_b(vb0), .vga_hsync(hs0), .vga_vsync(vs0),
        .vga_blank_n(bl0), .frame_start(fs0)
    );

    // Shrunken raster so whole frames fit in a short run.
    vga_scan_compositor #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x1), .y(y1),
        .spr_r(sr1), .spr_g(sg1), .spr_b(sb1c), .spr_a(sa1),
        .vga_r(vr1), .vga_g(vg1), .vga_b(vb1), .vga_hsync(hs1), .vga_vsync(vs1),
        .vga_blank_n(bl1), .frame_start(fs1)
    );

    localparam int HV[2] = '{640, 16};
    localparam int HF[2] = '{16, 2};
    localparam int HS[2] = '{96, 4};
    localparam int HB[2] = '{48, 3};
    localparam int VV[2] = '{480, 6};
    localparam int VF[2] = '{10, 1};
    localparam int VS[2] = '{2, 2};
    localparam int VB[2] = '{33, 1};

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } obs_t;

    typedef struct {
        int          inst;
        int          h;
        int          v;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } vec_t;

    localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, rgb: 24'h0, hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0};

    int   checks = 0;
    int   errors = 0;
    int   mh[2], mv[2];
    obs_t last[2];
    obs_t sbq0[$], sbq1[$];
    vec_t tbl[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t observe(input int i);
        obs_t o;
        if (i == 0) o = '{x: x0, y: y0, rgb: {vr0, vg0, vb0}, hs: hs0, vs: vs0, bl: bl0, fs: fs0};
        else        o = '{x: x1, y: y1, rgb: {vr1, vg1, vb1}, hs: hs1, vs: vs1, bl: bl1, fs: fs1};
        return o;
    endfunction

    // Reference model: expected registered outputs for the pixel at (mh,mv), then advance.
    task automatic predict(input int i, output obs_t e);
        int   h  = mh[i];
        int   v  = mv[i];
        int   ht = HV[i] + HF[i] + HS[i] + HB[i];
        int   vt = VV[i] + VF[i] + VS[i] + VB[i];
        logic vis = (h < HV[i]) && (v < VV[i]);
        logic a   = (i == 0) ? ((h == 100) && (v == 50)) : 1'b1;
        e.rgb = !vis ? 24'h0 : (a ? ((i == 0) ? 24'hFF0000 : 24'hFFFFFF) : 24'h000010);
        e.hs  = !((h >= HV[i] + HF[i]) && (h < HV[i] + HF[i] + HS[i]));
        e.vs  = !((v >= VV[i] + VF[i]) && (v < VV[i] + VF[i] + VS[i]));
        e.bl  = vis;
        e.fs  = (h == ht - 1) && (v == vt - 1);
        h = h + 1;
        if (h == ht) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end
        mh[i] = h;
        mv[i] = v;
        e.x = 10'(h);
        e.y = 10'(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mh[i]   = 0;
            mv[i]   = 0;
            last[i] = RST_OBS;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    // One clk: drive pix_en, push predictions, then compare after the edge.
    task automatic step(input bit en);
        obs_t e;
        @(negedge clk);
        pix_en = en;
        if (en) begin
            predict(0, e); sbq0.push_back(e);
            predict(1, e); sbq1.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (en) begin
                if (i == 0) e = sbq0.pop_front();
                else        e = sbq1.pop_front();
            end else begin
                e    = last[i];
                e.fs = 1'b0;
            end
            last[i] = e;
            chk((i == 0) ? "sb_dut0" : "sb_dut1", {16'h0, observe(i)}, {16'h0, e});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        pix_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int   cnt, first, n, fcnt0, fcnt1;
        obs_t o;

        tbl[0]  = '{0, 639, 1,  24'h000010, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{0, 640, 1,  24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{0, 655, 1,  24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{0, 656, 1,  24'h000000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{0, 751, 1,  24'h000000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{0, 752, 1,  24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{0, 799, 1,  24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{0, 99,  50, 24'h000010, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{0, 100, 50, 24'hFF0000, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{0, 101, 50, 24'h000010, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1, 0,   7,  24'h000000, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1, 24,  8,  24'h000000, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1, 0,   9,  24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1, 15,  0,  24'hFFFFFF, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1, 16,  0,  24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1, 18,  0,  24'h000000, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1, 21,  0,  24'h000000, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1, 22,  0,  24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1, 5,   5,  24'hFFFFFF, 1'b1, 1'b1, 1'b1};
        tbl[19] = '{1, 5,   6,  24'h000000, 1'b1, 1'b1, 1'b0};

        pix_en = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut0", {16'h0, observe(0)}, {16'h0, RST_OBS});
        chk("reset_dut1", {16'h0, observe(1)}, {16'h0, RST_OBS});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // One full line at a strobe every 2nd clk.
        cnt   = 0;
        first = 0;
        for (int k = 1; k <= 800; k++) begin
            step(1'b1);
            if (hs0 == 1'b0) begin
                cnt++;
                if (first == 0) first = k;
            end
            step(1'b0);
        end
        chk("hsync_low_strobes", 64'(cnt), 64'd96);
        chk("hsync_first_strobe", 64'(first), 64'd657);
        chk("line_wrap_xy", {44'h0, x0, y0}, {44'h0, 10'd0, 10'd1});

        // Vector table: run to each position, strobe it, compare registered outputs.
        foreach (tbl[t]) begin
            n = 0;
            while (!(mh[tbl[t].inst] == tbl[t].h && mv[tbl[t].inst] == tbl[t].v) && n < 60000) begin
                step(1'b1);
                n++;
            end
            chk($sformatf("tbl_reach_%0d", t), 64'(n < 60000), 64'd1);
            step(1'b1);
            o = observe(tbl[t].inst);
            chk($sformatf("tbl_vec_%0d", t), {37'h0, o.rgb, o.hs, o.vs, o.bl},
                {37'h0, tbl[t].rgb, tbl[t].hs, tbl[t].vs, tbl[t].bl});
        end

        // Asynchronous reset mid-line with pix_en held high.
        n = 0;
        while (mh[0] != 300 && n < 2000) begin
            step(1'b1);
            n++;
        end
        chk("mid_reach", 64'(mh[0]), 64'd300);
        @(negedge clk);
        pix_en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_dut0", {16'h0, observe(0)}, {16'h0, RST_OBS});
        chk("async_rst_dut1", {16'h0, observe(1)}, {16'h0, RST_OBS});
        @(negedge clk);
        pix_en = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        step(1'b1);
        chk("restart_pixel00", {35'h0, x0, y0, vr0, vg0, vb0, bl0},
            {35'h0, 10'd1, 10'd0, 24'h000010, 1'b1});

        // Frame pulses on the small raster: 750 strobes = 3 frames of 250.
        do_reset();
        fcnt0 = 0;
        fcnt1 = 0;
        for (int k = 0; k < 750; k++) begin
            step(1'b1);
            if (fs1) fcnt1++;
            if (fs0) fcnt0++;
            step(1'b0);
        end
        chk("frame_pulses_dut1", 64'(fcnt1), 64'd3);
        chk("frame_pulses_dut0", 64'(fcnt0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
